// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch front end.
// Holds the fetch FSM encoding, the queue entry layout and small address helpers.
package if_prefetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_WAIT  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] IF_INST_BYTES       = 32'd4;

    // One queue entry: pc occupies [63:32], inst occupies [31:0].
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + IF_INST_BYTES;
    endfunction

    function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                                input logic [31:0] inst);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Ring buffer of fetched {pc, inst} entries with push, pop and a flush that wins
// over both. Pointers are log2(DEPTH) bits and wrap on their own.
module if_prefetch_fetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           wr_data,
    input  logic                   pop,
    output fetch_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push  = push && !flush && (count_q != DEPTH_C);
        do_pop   = pop && !flush && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues word fetches to a variable-latency memory,
// queues returned words with their PCs, and handles decode stalls and redirects.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IF_RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   out_valid,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc4,
    input  logic                   out_ready,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] count,
    output if_state_e              dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Memory handshake: imem_req/imem_addr are registered and, once raised,
    // hold until the cycle imem_ack=1; that cycle both accepts the request and
    // returns imem_rdata. One request in flight at most; ack without req is ignored.

    if_state_e     state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   new_pc;
    logic          push;
    logic          pop;
    logic          flush;
    logic [CW-1:0] count_next;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;

    always_comb begin
        new_pc     = word_align(redirect_pc);
        flush      = redirect;
        pop        = out_valid && out_ready && !redirect;
        push       = imem_ack && (state_q == IF_WAIT) && !redirect;
        count_next = redirect ? '0 : (count + CW'(push) - CW'(pop));
        wr_entry   = make_entry(req_addr_q, imem_rdata);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;

        case (state_q)
            IF_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = new_pc;
                end
                // A request is only launched when a slot is reserved for its data.
                if (count_next < DEPTH_C) begin
                    state_d    = IF_WAIT;
                    req_addr_d = redirect ? new_pc : fetch_pc_q;
                end
            end
            IF_WAIT: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_d = new_pc;
                        req_addr_d = new_pc;
                    end else begin
                        fetch_pc_d = next_word(req_addr_q);
                        if (count_next < DEPTH_C) begin
                            req_addr_d = next_word(req_addr_q);
                        end else begin
                            state_d = IF_IDLE;
                        end
                    end
                end else if (redirect) begin
                    state_d    = IF_DRAIN;
                    fetch_pc_d = new_pc;
                end
            end
            IF_DRAIN: begin
                // The old request must complete; its data is thrown away.
                if (imem_ack) begin
                    state_d    = IF_WAIT;
                    req_addr_d = redirect ? new_pc : fetch_pc_q;
                    if (redirect) begin
                        fetch_pc_d = new_pc;
                    end
                end else if (redirect) begin
                    fetch_pc_d = new_pc;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    if_prefetch_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .count   (count)
    );

    assign imem_req  = (state_q != IF_IDLE);
    assign imem_addr = req_addr_q;
    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign out_pc4   = next_word(head.pc);
    assign dbg_state = state_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == DEPTH_C)));

    a_req_stable: assert property (@(posedge clk) disable iff (!rst)
        (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

endmodule
